// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronises and de-glitches the PS/2
// clock, shifts in 11-bit frames (start, 8 data LSB-first, odd parity, stop),
// and pulls the clock line low for a fixed time after any framing error.
module ps2_frame_rx #(
  parameter int unsigned CLK_FREQ   = 28000000,
  parameter int unsigned FILT_LEN   = 8,
  parameter int unsigned TIMEOUT_US = 200,
  parameter int unsigned INHIBIT_US = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_out,
  output logic       ps2_dat_out,
  output logic [7:0] dataout,
  output logic       dataout_valid,
  output logic       dataout_error
);

  localparam int unsigned CYC_PER_US = CLK_FREQ / 1000000;
  localparam int unsigned TO_CYC     = CYC_PER_US * TIMEOUT_US;
  localparam int unsigned INH_CYC    = CYC_PER_US * INHIBIT_US;
  localparam int unsigned TO_W       = $clog2(TO_CYC + 1);
  localparam int unsigned INH_W      = $clog2(INH_CYC + 1);
  localparam int unsigned FILT_W     = $clog2(FILT_LEN + 1);
  localparam int unsigned IDX_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_INHIBIT = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               clk_s1, clk_s2, dat_s1, dat_s2;
  logic               filt_clk;
  logic [FILT_W-1:0]  filt_cnt;
  logic               fall_stb;
  logic               dat_smp;
  logic [IDX_W-1:0]   bit_idx;
  logic [7:0]         shreg;
  logic               par_bit;
  logic [TO_W-1:0]    to_cnt;
  logic [INH_W-1:0]   inh_cnt;

  logic               stop_stb;
  logic               frame_ok;
  logic               timeout;
  logic               valid_nxt, error_nxt, clk_out_nxt;

  assign stop_stb = fall_stb && (bit_idx == IDX_W'(9));
  assign frame_ok = (^{shreg, par_bit}) && dat_smp;
  assign timeout  = !fall_stb && (to_cnt == TO_W'(TO_CYC - 1));

  // Two-flop synchronisers on both PS/2 pins
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat_in;
      dat_s2 <= dat_s1;
    end
  end

  // Clock level filter; a 1->0 acceptance raises the fall strobe and samples data
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall_stb <= 1'b0;
      dat_smp  <= 1'b0;
    end else begin
      fall_stb <= 1'b0;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_W'(FILT_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
        fall_stb <= filt_clk;
        dat_smp  <= dat_s2;
      end else begin
        filt_cnt <= filt_cnt + FILT_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (fall_stb && !dat_smp) state_nxt = ST_RECV;
      end
      ST_RECV: begin
        if (stop_stb)     state_nxt = frame_ok ? ST_IDLE : ST_INHIBIT;
        else if (timeout) state_nxt = ST_INHIBIT;
      end
      ST_INHIBIT: begin
        if (inh_cnt == INH_W'(INH_CYC - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    valid_nxt   = 1'b0;
    error_nxt   = 1'b0;
    clk_out_nxt = (state_nxt != ST_INHIBIT);
    if (state == ST_RECV) begin
      valid_nxt = stop_stb && frame_ok;
      error_nxt = (stop_stb && !frame_ok) || (!stop_stb && timeout);
    end
  end

  // Frame datapath, counters and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx       <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      to_cnt        <= '0;
      inh_cnt       <= '0;
      dataout       <= 8'h00;
      dataout_valid <= 1'b0;
      dataout_error <= 1'b0;
      ps2_clk_out   <= 1'b1;
      ps2_dat_out   <= 1'b1;
    end else begin
      dataout_valid <= valid_nxt;
      dataout_error <= error_nxt;
      ps2_clk_out   <= clk_out_nxt;
      ps2_dat_out   <= 1'b1;
      if (valid_nxt) dataout <= shreg;

      if (state == ST_RECV && fall_stb) begin
        if (bit_idx < IDX_W'(8))       shreg   <= {dat_smp, shreg[7:1]};
        else if (bit_idx == IDX_W'(8)) par_bit <= dat_smp;
      end

      if (state_nxt != ST_RECV)             bit_idx <= '0;
      else if (state == ST_RECV && fall_stb) bit_idx <= bit_idx + IDX_W'(1);

      if (state != ST_RECV || fall_stb) to_cnt <= '0;
      else                              to_cnt <= to_cnt + TO_W'(1);

      if (state == ST_INHIBIT) inh_cnt <= inh_cnt + INH_W'(1);
      else                     inh_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed plus randomised frame bench for ps2_frame_rx with a frame-level
// reference model and a pulse/hold protocol monitor.
module tb_ps2_frame_rx;

  localparam int unsigned CLK_FREQ   = 4000000;
  localparam int unsigned FILT_LEN   = 8;
  localparam int unsigned TIMEOUT_US = 200;
  localparam int unsigned INHIBIT_US = 100;
  localparam int unsigned TO_CYC     = (CLK_FREQ / 1000000) * TIMEOUT_US;
  localparam int unsigned INH_CYC    = (CLK_FREQ / 1000000) * INHIBIT_US;
  localparam int unsigned HALF       = CLK_FREQ / 12500 / 2;  // 12.5 kHz PS/2 clock

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk_in = 1'b1;
  logic       ps2_dat_in = 1'b1;
  logic       ps2_clk_out, ps2_dat_out;
  logic [7:0] dataout;
  logic       dataout_valid, dataout_error;

  ps2_frame_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .FILT_LEN  (FILT_LEN),
    .TIMEOUT_US(TIMEOUT_US),
    .INHIBIT_US(INHIBIT_US)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_in   (ps2_clk_in),
    .ps2_dat_in   (ps2_dat_in),
    .ps2_clk_out  (ps2_clk_out),
    .ps2_dat_out  (ps2_dat_out),
    .dataout      (dataout),
    .dataout_valid(dataout_valid),
    .dataout_error(dataout_error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Protocol monitor sampled on the falling edge
  int          tests = 0, fails = 0;
  int          nvalid = 0, nerr = 0, viol = 0;
  int          low_run = 0, last_low_run = 0, nlow_runs = 0;
  int unsigned err_cyc = 0;
  logic [7:0]  vq[$];
  logic        pv = 1'b0, pe = 1'b0, rst_d = 1'b1;
  logic [7:0]  pd = 8'h00;

  always @(negedge clk) begin
    if (dataout_valid && dataout_error) viol++;
    if (dataout_valid && pv) viol++;
    if (dataout_error && pe) viol++;
    if (!rst && !rst_d && !dataout_valid && dataout !== pd) viol++;
    if (dataout_valid) begin nvalid++; vq.push_back(dataout); end
    if (dataout_error) begin nerr++; err_cyc = cyc; end
    if (!ps2_clk_out) low_run++;
    else if (low_run != 0) begin last_low_run = low_run; nlow_runs++; low_run = 0; end
    pv = dataout_valid; pe = dataout_error; pd = dataout; rst_d = rst;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: frame bits {stop, parity, data, start}
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    logic p;
    p = ~(^d) ^ par_flip;
    return {stop, p, d, 1'b0};
  endfunction

  function automatic logic model_ok(input logic [10:0] f);
    return (f[0] == 1'b0) && ((^f[9:1]) == 1'b1) && (f[10] == 1'b1);
  endfunction

  int unsigned last_fall = 0;
  logic [7:0]  exp_dout = 8'h00;

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat_in = f[i];
      wait_cyc(HALF);
      ps2_clk_in = 1'b0;
      last_fall  = cyc;
      wait_cyc(HALF);
      ps2_clk_in = 1'b1;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic flip, input logic stop);
    logic [10:0] f;
    logic        ok;
    int          nv0, ne0, nl0;
    f   = mk_frame(d, flip, stop);
    ok  = model_ok(f);
    nv0 = nvalid; ne0 = nerr; nl0 = nlow_runs;
    send_bits(f, 11);
    wait_cyc(40);
    if (ok) exp_dout = d;
    check({tag, "_valid"}, 32'(nvalid - nv0), 32'(ok));
    check({tag, "_error"}, 32'(nerr - ne0), 32'(!ok));
    check({tag, "_dout"}, 32'(dataout), 32'(exp_dout));
    if (!ok) begin
      wait_cyc(INH_CYC + 60);
      check({tag, "_inh_len"}, 32'(last_low_run), 32'(INH_CYC));
    end
    check({tag, "_inh_runs"}, 32'(nlow_runs - nl0), 32'(!ok));
    check({tag, "_clk_rel"}, 32'(ps2_clk_out), 32'(1));
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  logic [10:0] fr;
  int          nv0, ne0, waited, el, kind;
  logic [7:0]  rb;

  initial begin
    // Reset state
    rst = 1'b1;
    wait_cyc(3);
    check("rst_dout", 32'(dataout), 32'(8'h00));
    check("rst_valid", 32'(dataout_valid), 32'(0));
    check("rst_error", 32'(dataout_error), 32'(0));
    check("rst_clk_out", 32'(ps2_clk_out), 32'(1));
    check("rst_dat_out", 32'(ps2_dat_out), 32'(1));
    rst = 1'b0;
    wait_cyc(20);

    // Single good frame
    run_frame("f1C", 8'h1C, 1'b0, 1'b1);

    // Back-to-back frames
    nv0 = nvalid; ne0 = nerr;
    send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 11);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
    wait_cyc(40);
    exp_dout = 8'h1C;
    check("b2b_valid", 32'(nvalid - nv0), 32'(2));
    check("b2b_error", 32'(nerr - ne0), 32'(0));
    check("b2b_first", 32'(vq[vq.size() - 2]), 32'(8'hF0));
    check("b2b_second", 32'(vq[vq.size() - 1]), 32'(8'h1C));

    // Bad parity: error, dataout held, clock inhibited
    run_frame("par", 8'h1C, 1'b1, 1'b1);

    // Timeout after start + 4 data bits
    nv0 = nvalid; ne0 = nerr;
    send_bits(mk_frame(8'hA5, 1'b0, 1'b1), 5);
    waited = 0;
    while (nerr == ne0 && waited < 3000) begin
      wait_cyc(1);
      waited++;
    end
    el = int'(err_cyc - last_fall);
    check("to_err_cnt", 32'(nerr - ne0), 32'(1));
    check("to_window", 32'(nerr != ne0 && el >= int'(TO_CYC) && el <= int'(TO_CYC) + 40), 32'(1));
    check("to_novalid", 32'(nvalid - nv0), 32'(0));
    wait_cyc(INH_CYC + 60);
    check("to_inh_len", 32'(last_low_run), 32'(INH_CYC));
    check("to_dout", 32'(dataout), 32'(exp_dout));

    // Glitch of FILT_LEN-1 cycles with data low while idle
    nv0 = nvalid; ne0 = nerr;
    ps2_dat_in = 1'b0;
    ps2_clk_in = 1'b0;
    wait_cyc(FILT_LEN - 1);
    ps2_clk_in = 1'b1;
    ps2_dat_in = 1'b1;
    wait_cyc(40);
    check("glitch_pulses", 32'((nvalid - nv0) + (nerr - ne0)), 32'(0));
    run_frame("f5A", 8'h5A, 1'b0, 1'b1);

    // Reset mid-frame, then a full frame
    send_bits(mk_frame(8'h77, 1'b0, 1'b1), 6);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    exp_dout = 8'h00;
    check("mrst_dout", 32'(dataout), 32'(8'h00));
    nv0 = nvalid; ne0 = nerr;
    wait_cyc(TO_CYC + 100);
    check("mrst_pulses", 32'((nvalid - nv0) + (nerr - ne0)), 32'(0));
    run_frame("f29", 8'h29, 1'b0, 1'b1);

    // Reset during inhibit releases the clock at once
    send_bits(mk_frame(8'h3C, 1'b0, 1'b0), 11);
    wait_cyc(20);
    check("irst_in_inh", 32'(ps2_clk_out), 32'(0));
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    exp_dout = 8'h00;
    check("irst_clk_rel", 32'(ps2_clk_out), 32'(1));
    nv0 = nvalid; ne0 = nerr;
    wait_cyc(INH_CYC + 20);
    check("irst_pulses", 32'((nvalid - nv0) + (nerr - ne0)), 32'(0));
    check("irst_clk_stay", 32'(ps2_clk_out), 32'(1));

    // Randomised frames: good, bad parity, bad stop
    for (int k = 0; k < 6; k++) begin
      rb   = 8'($urandom);
      kind = int'($urandom_range(0, 3));
      run_frame($sformatf("rnd%0d", k), rb, kind == 2, kind != 3);
    end

    check("protocol_viol", 32'(viol), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 28000000, system clock frequency in Hz.
REQ-002 SHALL have parameter FILT_LEN, default 8, number of consecutive equal samples required to accept a PS/2 clock level change.
REQ-003 SHALL have parameter TIMEOUT_US, default 200, maximum gap in microseconds between falling edges inside one frame.
REQ-004 SHALL have parameter INHIBIT_US, default 100, duration in microseconds of the clock-inhibit pulse after an error.
REQ-005 SHALL have port clk, input, 1 bit, system clock; the block uses only this one clock.
REQ-006 SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-007 SHALL have port ps2_clk_in, input, 1 bit, PS/2 clock pin sense; it is asynchronous to clk.
REQ-008 SHALL have port ps2_dat_in, input, 1 bit, PS/2 data pin sense; it is asynchronous to clk.
REQ-009 SHALL have port ps2_clk_out, output, 1 bit, open-drain control: 0 pulls the clock line low, 1 releases it.
REQ-010 SHALL have port ps2_dat_out, output, 1 bit, open-drain data control; it is held at constant 1 (released).
REQ-011 SHALL have port dataout, output, 8 bits, last correctly received byte.
REQ-012 SHALL have port dataout_valid, output, 1 bit, one-cycle pulse when a byte is accepted.
REQ-013 SHALL have port dataout_error, output, 1 bit, one-cycle pulse when a frame is rejected.

Function
REQ-014 SHALL pass ps2_clk_in and ps2_dat_in through two-flop synchronisers before any other use.
REQ-015 SHALL change the filtered clock level only after FILT_LEN consecutive synchronised samples that differ from the current filtered level.
- Any shorter pulse is ignored.
- The filtered level resets to 1.
REQ-016 SHALL generate a one-cycle fall strobe on each 1->0 transition of the filtered clock, and sample synchronised data on that same cycle.
REQ-017 SHALL implement the states IDLE, RECV and INHIBIT.
REQ-018 In IDLE, on a fall strobe:
- sampled data 0 (start bit): go to RECV with bit index 0;
- sampled data 1: stay in IDLE with no error pulse (resync).
REQ-019 In RECV, SHALL treat the frame as follows:
- fall strobes 1..8 shift data LSB-first into the shift register;
- strobe 9 captures the parity bit;
- strobe 10 captures the stop bit.
REQ-020 On the stop-bit strobe, if parity is odd over data plus parity bit AND the stop bit is 1:
- dataout is loaded and dataout_valid pulses on the next clk cycle;
- the state returns to IDLE.
REQ-021 On the stop-bit strobe, if the parity is wrong or the stop bit is 0:
- dataout_error pulses on the next clk cycle;
- dataout is unchanged;
- the state goes to INHIBIT.
REQ-022 SHALL run a timeout counter in RECV that clears on every fall strobe.
- Width: ceil(log2(CLK_FREQ/1000000*TIMEOUT_US + 1)) bits.
- On reaching CLK_FREQ/1000000*TIMEOUT_US cycles without a strobe: pulse dataout_error once, discard the partial byte, go to INHIBIT.
REQ-023 In INHIBIT, SHALL behave as follows:
- drive ps2_clk_out = 0 for exactly CLK_FREQ/1000000*INHIBIT_US cycles;
- then release to 1 and return to IDLE;
- ignore all fall strobes while in INHIBIT.
REQ-024 dataout_valid and dataout_error SHALL never be asserted in the same cycle, and each SHALL be high for exactly one cycle per event.
REQ-025 dataout SHALL hold its value between valid pulses.
REQ-026 Back-to-back frames SHALL be accepted with no dead time: a start-bit strobe in the cycle after return to IDLE is honoured.
REQ-027 ps2_clk_out SHALL be 1 in every state except INHIBIT.

Reset
REQ-028 While rst is high at a clk edge, the block SHALL set:
- state = IDLE;
- dataout = 8'h00;
- dataout_valid = 0 and dataout_error = 0;
- ps2_clk_out = 1 and ps2_dat_out = 1;
- filtered clock = 1;
- synchronisers = 1;
- all counters = 0.
REQ-029 Reset asserted mid-frame or mid-inhibit SHALL discard the partial frame.
- No valid or error pulse SHALL follow.
- ps2_clk_out SHALL be released in the first cycle after reset.

Verification
REQ-030 SHALL cover: frame start 0, data 0x1C LSB-first, parity 0, stop 1, at 12.5 kHz -> one dataout_valid pulse, dataout = 8'h1C, no error.
REQ-031 SHALL cover: frames 0xF0 then 0x1C sent back-to-back -> two valid pulses, dataout 8'hF0 then 8'h1C.
REQ-032 SHALL cover: 0x1C sent with parity bit 1 -> one dataout_error pulse, dataout unchanged, then ps2_clk_out = 0 for INHIBIT_US*CLK_FREQ/1e6 cycles, then 1.
REQ-033 SHALL cover: clock stopped after 4 data bits for more than 200 us -> one dataout_error pulse at the timeout count, no valid pulse.
REQ-034 SHALL cover: a clock glitch low of FILT_LEN-1 cycles while idle -> no state change and no pulses; the following valid frame 0x5A is received correctly.
REQ-035 SHALL cover: rst asserted for one cycle after 6 bits of a frame, then a full 0x29 frame -> no pulse for the aborted frame, one valid pulse with dataout = 8'h29.
